// File: rtl/layer_mac_scheduler_if.sv
// Handshake and weight-ROM signals of the layer MAC scheduler.
// master = scheduler side, slave = surrounding layer logic and weight ROM.
interface layer_mac_scheduler_if #(
    parameter int NUM_IN    = 5,
    parameter int NUM_NODES = 8,
    parameter int AW        = 6
);
    localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [32*NUM_IN-1:0]  in_data;
    logic [AW-1:0]         w_addr;
    logic [31:0]           w_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IW-1:0]         out_idx;
    logic [31:0]           out_data;

    modport master (
        input  in_valid, in_data, w_data, out_ready,
        output in_ready, w_addr, out_valid, out_idx, out_data
    );

    modport slave (
        output in_valid, in_data, w_data, out_ready,
        input  in_ready, w_addr, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/layer_mac_scheduler.sv
// One shared 32-bit MAC evaluates every neuron of a fully connected layer in turn.
// Define LAYER_SCHED_RELU_EN for ReLU activation; otherwise the raw sum is emitted.
module layer_mac_scheduler #(
    parameter int NUM_IN    = 5,
    parameter int NUM_NODES = 8,
    parameter int AW        = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    layer_mac_scheduler_if.master bus,
    output logic                  busy,
    output logic                  layer_done
);
    // state | meaning
    // IDLE  | waiting for an input vector
    // RUN   | issuing weight addresses and accumulating returned data
    // OUT   | holding the activated node result until accepted
    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int KW = $clog2(NUM_IN + 2);
    localparam logic [KW-1:0] K_ADDR_LAST = KW'(NUM_IN);
    localparam logic [KW-1:0] K_BIAS      = KW'(NUM_IN + 1);
    localparam logic [IW-1:0] LAST_NODE   = IW'(NUM_NODES - 1);

    state_t               state, state_nxt;
    logic [32*NUM_IN-1:0] vec;
    logic [31:0]          acc, a_sel, prod, act;
    logic [IW-1:0]        node;
    logic [KW-1:0]        k_cnt;
    logic                 started, accept, out_fire, last_node;

    assign accept    = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign last_node = (node == LAST_NODE);

    // k_cnt runs one ahead of the element whose weight is on w_data
    always_comb begin
        a_sel = 32'd0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (k_cnt == KW'(i + 1)) a_sel = vec[32*i +: 32];
        end
        prod = a_sel * bus.w_data;
    end

`ifdef LAYER_SCHED_RELU_EN
    assign act = acc[31] ? 32'd0 : acc;
`else
    assign act = acc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (k_cnt == K_BIAS) state_nxt = OUT;
            OUT:  if (out_fire) state_nxt = last_node ? IDLE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        busy          = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_idx   = '0;
        bus.out_data  = 32'd0;
        case (state)
            IDLE: bus.in_ready = started;
            RUN:  busy = 1'b1;
            OUT: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_idx   = node;
                bus.out_data  = act;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec        <= '0;
            acc        <= 32'd0;
            node       <= '0;
            k_cnt      <= '0;
            bus.w_addr <= '0;
            started    <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            started    <= 1'b1;
            layer_done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    vec        <= bus.in_data;
                    node       <= '0;
                    k_cnt      <= '0;
                    acc        <= 32'd0;
                    bus.w_addr <= '0;
                end
                RUN: begin
                    k_cnt <= k_cnt + KW'(1);
                    if (k_cnt < K_ADDR_LAST) bus.w_addr <= bus.w_addr + AW'(1);
                    if (k_cnt != '0) acc <= acc + ((k_cnt == K_BIAS) ? bus.w_data : prod);
                end
                OUT: if (out_fire) begin
                    if (last_node) begin
                        layer_done <= 1'b1;
                    end else begin
                        // w_addr sits on the bias of this node, so +1 is the next node base
                        node       <= node + IW'(1);
                        acc        <= 32'd0;
                        k_cnt      <= '0;
                        bus.w_addr <= bus.w_addr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Bench for layer_mac_scheduler: table vectors, hand-written corner sequences and random layers
// checked against a plain-arithmetic neuron model over a behavioural weight ROM.
module tb_layer_mac_scheduler;
    localparam int NUM_IN    = 5;
    localparam int NUM_NODES = 8;
    localparam int AW        = 6;
    localparam int STRIDE    = NUM_IN + 1;
    localparam int NREC      = 6;

    typedef logic [NUM_IN-1:0][31:0] vec_t;
    typedef struct packed {
        vec_t        a;
        vec_t        w;
        logic [31:0] b;
        logic [31:0] sum;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    logic busy, layer_done;
    int   cyc = 0;
    int   done_pulses = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [31:0] rom [2**AW];
    rec_t tbl [NREC];

    layer_mac_scheduler_if #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES), .AW(AW)) bus ();

    layer_mac_scheduler #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .layer_done (layer_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) bus.w_data <= rom[bus.w_addr];
    always @(negedge clk) if (layer_done) done_pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
    endtask

    function automatic vec_t mk5(input logic [31:0] v0, v1, v2, v3, v4);
        return {v4, v3, v2, v1, v0};
    endfunction

    function automatic logic [31:0] act_fn(input logic [31:0] s);
`ifdef LAYER_SCHED_RELU_EN
        return s[31] ? 32'd0 : s;
`else
        return s;
`endif
    endfunction

    // Neuron n: bias + sum of A[k]*W[k], everything modulo 2^32
    function automatic logic [31:0] node_sum(input int n, input vec_t a);
        logic [31:0] s;
        s = rom[n*STRIDE + NUM_IN];
        for (int k = 0; k < NUM_IN; k++) s = s + a[k] * rom[n*STRIDE + k];
        return s;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < NUM_IN; k++) v[k] = $urandom;
        return v;
    endfunction

    task automatic fill_rom_random();
        for (int i = 0; i < 2**AW; i++) rom[i] = $urandom;
    endtask

    task automatic load_rec(input rec_t r);
        for (int k = 0; k < NUM_IN; k++) rom[k] = r.w[k];
        rom[NUM_IN] = r.b;
    endtask

    // Runs one layer; all driving and sampling happens on the falling edge.
    task automatic run_layer(input vec_t a, input vec_t a_junk, input bit overlap, input bit rnd_rdy,
                             input int hold_node, input int hold_cycles, input int abort_node,
                             input string tag, input bit chk0, input logic [31:0] exp0);
        logic [31:0]   want_q [NUM_NODES];
        logic [31:0]   want, cap_data;
        logic [2:0]    cap_idx;
        int            g, node, t_ref, hold_left, run_cyc, d0;
        bit            seen, stable_ok, busy_ok, aborted;
        for (int n = 0; n < NUM_NODES; n++) want_q[n] = act_fn(node_sum(n, a));
        d0 = done_pulses;
        @(negedge clk);
        bus.in_data   = a;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        g = 0;
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({tag, " accept"}, 32'(bus.in_ready), 32'd1);
        t_ref = cyc;
        node = 0; seen = 0; stable_ok = 1; busy_ok = 1; aborted = 0;
        hold_left = hold_cycles; run_cyc = 0; g = 0;
        cap_idx = '0; cap_data = '0;
        while (node < NUM_NODES && !aborted && g < 4000) begin
            @(negedge clk);
            g++;
            if (g == 1) begin
                if (overlap) bus.in_data = a_junk;
                else         bus.in_valid = 1'b0;
            end
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) busy_ok = 0;
            if (node == abort_node && !bus.out_valid) begin
                run_cyc++;
                if (run_cyc == 3) begin
                    reset = 1'b0;
                    #1;
                    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
                    check({tag, " busy"}, 32'(busy), 32'd0);
                    check({tag, " w_addr"}, 32'(bus.w_addr), 32'd0);
                    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
                    @(negedge clk);
                    reset = 1'b1;
                    aborted = 1;
                end
            end
            if (!aborted && bus.out_valid) begin
                if (!seen) begin
                    seen = 1;
                    want = (node == 0 && chk0) ? exp0 : want_q[node];
                    check($sformatf("%s n%0d latency", tag, node), 32'(cyc - t_ref), 32'(NUM_IN + 3));
                    check($sformatf("%s n%0d idx", tag, node), 32'(bus.out_idx), 32'(node));
                    check($sformatf("%s n%0d data", tag, node), bus.out_data, want);
                    cap_idx  = bus.out_idx;
                    cap_data = bus.out_data;
                end else if (bus.out_idx !== cap_idx || bus.out_data !== cap_data) begin
                    stable_ok = 0;
                end
                if (node == hold_node && hold_left > 0) begin
                    bus.out_ready = 1'b0;
                    hold_left--;
                end else begin
                    bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (bus.out_ready) begin
                    t_ref = cyc;
                    node++;
                    seen = 0;
                    if (node == NUM_NODES) bus.in_valid = 1'b0;
                end
            end else if (!aborted) begin
                bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (abort_node >= 0) begin
            check({tag, " reached abort"}, 32'(aborted), 32'd1);
            @(negedge clk);
            check({tag, " no layer_done"}, 32'(done_pulses - d0), 32'd0);
        end else begin
            check({tag, " nodes emitted"}, 32'(node), 32'(NUM_NODES));
            check({tag, " busy/in_ready in layer"}, 32'(busy_ok), 32'd1);
            if (hold_node >= 0) check({tag, " held output stable"}, 32'(stable_ok), 32'd1);
            @(negedge clk);
            check({tag, " layer_done pulse"}, 32'(layer_done), 32'd1);
            check({tag, " idle busy"}, 32'(busy), 32'd0);
            check({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            check({tag, " layer_done low"}, 32'(layer_done), 32'd0);
            check({tag, " layer_done count"}, 32'(done_pulses - d0), 32'd1);
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2**AW; i++) rom[i] = 32'd0;

        tbl[0] = '{a: mk5(1, 2, 3, 4, 5),
                   w: mk5(8141, 1153, 5219, 32'(-8110), 32'(-7569)),
                   b: 195, sum: 32'(-43986)};
        tbl[1] = '{a: mk5(10, 0, 0, 0, 0),
                   w: mk5(8141, 1153, 5219, 32'(-8110), 32'(-7569)),
                   b: 195, sum: 81605};
        tbl[2] = '{a: mk5(32'h40000000, 32'h40000000, 0, 0, 0),
                   w: mk5(4, 6, 0, 0, 0), b: 7, sum: 32'h80000007};
        tbl[3] = '{a: mk5(32'(-3), 7, 2, 0, 100),
                   w: mk5(32'(-5), 2, 9, 1000, 32'(-1)), b: 100, sum: 47};
        tbl[4] = '{a: mk5(32'h7FFFFFFF, 0, 0, 0, 0),
                   w: mk5(1, 0, 0, 0, 0), b: 0, sum: 32'h7FFFFFFF};
        tbl[5] = '{a: mk5(32'h7FFFFFFF, 1, 0, 0, 0),
                   w: mk5(1, 1, 0, 0, 0), b: 0, sum: 32'h80000000};

        repeat (3) begin
            @(negedge clk);
            check("reset in_ready", 32'(bus.in_ready), 32'd0);
        end
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_idx", 32'(bus.out_idx), 32'd0);
        check("reset out_data", bus.out_data, 32'd0);
        check("reset w_addr", 32'(bus.w_addr), 32'd0);
        check("reset layer_done", 32'(layer_done), 32'd0);
        reset = 1'b1;
        #1;
        check("release in_ready before edge", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("release in_ready after edge", 32'(bus.in_ready), 32'd1);
        check("release busy", 32'(busy), 32'd0);

        for (int i = 0; i < NREC; i++) begin
            fill_rom_random();
            load_rec(tbl[i]);
            run_layer(tbl[i].a, '0, 0, 0, -1, 0, -1, $sformatf("vec%0d", i), 1, act_fn(tbl[i].sum));
        end

        fill_rom_random();
        run_layer(rand_vec(), '0, 0, 0, 3, 4, -1, "backpressure", 0, 32'd0);

        fill_rom_random();
        run_layer(rand_vec(), rand_vec(), 1, 0, -1, 0, -1, "overlap", 0, 32'd0);

        for (int i = 0; i < 6; i++) begin
            fill_rom_random();
            run_layer(rand_vec(), '0, 0, 1, -1, 0, -1, $sformatf("rnd%0d", i), 0, 32'd0);
        end

        fill_rom_random();
        run_layer(rand_vec(), '0, 0, 0, -1, 0, 2, "abort", 0, 32'd0);
        load_rec(tbl[0]);
        run_layer(tbl[0].a, '0, 0, 0, -1, 0, -1, "post_abort", 1, act_fn(tbl[0].sum));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
